// File: rtl/sensor_state.sv
// Free-running frame sequencer for the pixel array: IDLE, then erase, expose,
// ramp-convert and row readout, repeating until reset.
module sensor_state #(
   parameter int PIXEL_ARRAY_HEIGHT = 2,
   parameter int PIXEL_ARRAY_WIDTH  = 2,
   parameter int PIXEL_BITS         = 8,
   parameter int ERASE_CYCLES       = 5,
   parameter int EXPOSE_CYCLES      = 255,
   parameter int ROW_READ_CYCLES    = 1
) (
   input  logic                          CLK,
   input  logic                          RESET,
   output logic                          PIXEL_ERASE,
   output logic                          PIXEL_EXPOSE,
   output logic [PIXEL_ARRAY_HEIGHT-1:0] SENSOR_ROW_SELECT,
   output logic [PIXEL_BITS-1:0]         PIXEL_CONVERT_COUNTER
);

   localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ERASE   = 3'd1;
   localparam logic [2:0] S_EXPOSE  = 3'd2;
   localparam logic [2:0] S_CONVERT = 3'd3;
   localparam logic [2:0] S_READ    = 3'd4;

   localparam logic [15:0]      ERASE_LAST  = 16'(ERASE_CYCLES - 1);
   localparam logic [15:0]      EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
   localparam logic [15:0]      CONV_LAST   = 16'((1 << PIXEL_BITS) - 1);
   localparam logic [15:0]      READ_LAST   = 16'(ROW_READ_CYCLES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

   // Column count does not affect sequencing; it is only sanity-checked here.
   if (PIXEL_ARRAY_WIDTH < 1 || PIXEL_ARRAY_HEIGHT < 1 || PIXEL_BITS < 1 || PIXEL_BITS > 16 ||
       ERASE_CYCLES < 1 || EXPOSE_CYCLES < 1 || ROW_READ_CYCLES < 1) begin : g_bad_cfg
      $error("sensor_state: invalid parameter set");
   end

   logic [2:0]                    r_state;
   logic [15:0]                   r_cnt;
   logic [ROW_W-1:0]              r_row;
   logic [PIXEL_ARRAY_HEIGHT-1:0] w_row_sel;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_ERASE;
               r_cnt   <= '0;
            end
            S_ERASE: begin
               if (r_cnt == ERASE_LAST) begin
                  r_state <= S_EXPOSE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_EXPOSE: begin
               if (r_cnt == EXPOSE_LAST) begin
                  r_state <= S_CONVERT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_CONVERT: begin
               if (r_cnt == CONV_LAST) begin
                  r_state <= S_READ;
                  r_cnt   <= '0;
                  r_row   <= '0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_READ: begin
               if (r_cnt == READ_LAST) begin
                  r_cnt <= '0;
                  // Last row wraps straight into the next frame's erase.
                  if (r_row == ROW_LAST) begin
                     r_state <= S_ERASE;
                     r_row   <= '0;
                  end else begin
                     r_row <= r_row + ROW_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_row   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      w_row_sel = '0;
      for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
         if (r_state == S_READ && r_row == ROW_W'(i)) w_row_sel[i] = 1'b1;
      end
   end

   assign PIXEL_ERASE           = (r_state == S_ERASE);
   assign PIXEL_EXPOSE          = (r_state == S_EXPOSE);
   assign SENSOR_ROW_SELECT     = w_row_sel;
   assign PIXEL_CONVERT_COUNTER = (r_state == S_CONVERT) ? r_cnt[PIXEL_BITS-1:0] : '0;

endmodule

// File: tb/tb_sensor_state.sv
// Scoreboard bench for sensor_state: default instance plus a small-ramp, 4-row instance.
module tb_sensor_state;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       erA, exA, erB, exB;
   logic [1:0] rowA;
   logic [7:0] cntA;
   logic [3:0] rowB;
   logic [3:0] cntB;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rel_cyc = 0;
   logic [13:0] qa[$];
   logic [13:0] qb[$];
   int risesA[$];
   int risesB[$];
   logic prevA = 1'b0;
   logic prevB = 1'b0;

   sensor_state u_a (
      .CLK(CLK), .RESET(RESET),
      .PIXEL_ERASE(erA), .PIXEL_EXPOSE(exA),
      .SENSOR_ROW_SELECT(rowA), .PIXEL_CONVERT_COUNTER(cntA)
   );

   sensor_state #(
      .PIXEL_ARRAY_HEIGHT(4), .PIXEL_BITS(4), .ROW_READ_CYCLES(3)
   ) u_b (
      .CLK(CLK), .RESET(RESET),
      .PIXEL_ERASE(erB), .PIXEL_EXPOSE(exB),
      .SENSOR_ROW_SELECT(rowB), .PIXEL_CONVERT_COUNTER(cntB)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected {erase, expose, rowsel[3:0], count[7:0]} k rising edges after reset release,
   // with the erase/expose lengths fixed at 5 and 255.
   function automatic logic [13:0] model(input int k, input int pb, input int h, input int rr);
      int p, conv, period;
      logic [13:0] v;
      v = '0;
      conv = 1 << pb;
      period = 5 + 255 + conv + h * rr;
      if (k > 0) begin
         p = (k - 1) % period;
         if (p < 5) v[13] = 1'b1;
         else if (p < 260) v[12] = 1'b1;
         else if (p < 260 + conv) v[7:0] = 8'(p - 260);
         else v[11:8] = 4'(1 << ((p - 260 - conv) / rr));
      end
      return v;
   endfunction

   function automatic logic [13:0] actA();
      return {erA, exA, 2'b00, rowA, cntA};
   endfunction

   function automatic logic [13:0] actB();
      return {erB, exB, rowB, 4'b0000, cntB};
   endfunction

   task automatic push(input int k);
      qa.push_back(model(k, 8, 2, 1));
      qb.push_back(model(k, 4, 4, 3));
   endtask

   // Monitor: pops one expected vector per DUT each cycle and checks invariants.
   always @(negedge CLK) begin
      logic [13:0] ea, eb;
      if (qa.size() > 0 && qb.size() > 0) begin
         ea = qa.pop_front();
         eb = qb.pop_front();
         check("dutA_outputs", 32'(actA()), 32'(ea));
         check("dutB_outputs", 32'(actB()), 32'(eb));
         check("dutA_exclusive",
               32'((32'(erA) + 32'(exA) + 32'(cntA != 0) + 32'(rowA != 0)) <= 1 && $onehot0(rowA)), 32'd1);
         check("dutB_exclusive",
               32'((32'(erB) + 32'(exB) + 32'(cntB != 0) + 32'(rowB != 0)) <= 1 && $onehot0(rowB)), 32'd1);
      end
      if (erA && !prevA) risesA.push_back(cyc);
      if (erB && !prevB) risesB.push_back(cyc);
      prevA = erA;
      prevB = erB;
   end

   initial begin
      RESET = 1'b0;
      repeat (3) begin
         @(posedge CLK);
         #1 push(0);
      end
      #1 RESET = 1'b1;
      rel_cyc = cyc;
      for (int k = 1; k <= 1200; k++) begin
         @(posedge CLK);
         #1 push(k);
      end
      @(posedge CLK);

      check("riseA_count_ok", 32'(risesA.size() >= 2), 32'd1);
      check("riseB_count_ok", 32'(risesB.size() >= 2), 32'd1);
      if (risesA.size() >= 2) begin
         check("first_erase_delay", 32'(risesA[0] - rel_cyc), 32'd1);
         check("frame_period_A", 32'(risesA[1] - risesA[0]), 32'd518);
      end
      if (risesB.size() >= 2) check("frame_period_B", 32'(risesB[1] - risesB[0]), 32'd288);

      // Second run: reset mid-CONVERT when the ramp reaches 100.
      #1 RESET = 1'b0;
      repeat (2) begin
         @(posedge CLK);
         #1 push(0);
      end
      #1 RESET = 1'b1;
      for (int k = 1; k <= 361; k++) begin
         @(posedge CLK);
         if (k < 361) #1 push(k);
      end
      #1 check("ramp_at_100", 32'(cntA), 32'd100);
      #1 RESET = 1'b0;
      #1 begin
         check("async_reset_A", 32'(actA()), 32'd0);
         check("async_reset_B", 32'(actB()), 32'd0);
      end
      repeat (2) begin
         @(posedge CLK);
         #1 push(0);
      end
      #1 RESET = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge CLK);
         #1 push(k);
      end
      repeat (2) @(negedge CLK);
      check("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
